// File: rtl/cpu_parameters.sv
// Shared CPU-wide parameters: datapath width and the fetch FSM state type.
package cpu_parameters;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_RSP = 2'd1,
        DRAIN    = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO with synchronous clear and occupancy count.
module ifetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    // Popping an empty buffer is silently ignored.
    assign do_pop   = pop && (count != '0);
    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small decode buffer.
module ifetch_unit
    import cpu_parameters::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] target,
    input  logic            target_valide,
    input  logic            flush,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_pc;
    logic [CW-1:0]    fifo_count;
    logic [31+XLEN:0] fifo_out;
    logic             outstanding;
    logic             accept;
    logic             push;

    assign outstanding   = (state != FETCH);
    assign mem_req_valid = !rst && (state == FETCH)
                           && ((fifo_count + CW'(outstanding)) < CW'(FIFO_DEPTH));
    assign mem_req_addr  = pc;
    assign accept        = mem_req_valid && mem_req_ready;
    assign push          = (state == WAIT_RSP) && mem_rsp_valid && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            // A redirect wins over the +4 advance; an accepted request keeps its own address in req_pc.
            if (target_valide) begin
                pc <= word_align(target);
            end else if (accept) begin
                pc <= pc + XLEN'(4);
            end
            if (accept) begin
                req_pc <= pc;
            end
            unique case (state)
                FETCH: begin
                    // A flush on the accepting edge still leaves a response to swallow.
                    if (accept) begin
                        state <= flush ? DRAIN : WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        state <= FETCH;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_rsp_valid) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    ifetch_fifo #(
        .WIDTH (32 + XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data ({mem_rsp_data, req_pc}),
        .pop       (instr_ready),
        .pop_data  (fifo_out),
        .count     (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = fifo_out[31+XLEN:XLEN];
    assign instr_pc    = fifo_out[XLEN-1:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: memory model plus scoreboard of expected decode words.
module tb_ifetch_unit;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] target = '0;
    logic        target_valide = 1'b0;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    ifetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .target        (target),
        .target_valide (target_valide),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_pc;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    bit          discard;
    int          lat = 1;
    bit          dec_rdy;
    int          tests = 0;
    int          fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // One clock cycle: drive at negedge, observe 1ns later, update the model for the coming posedge.
    task automatic cycle(input bit rdy, input bit tv, input bit fl, input logic [31:0] tgt);
        bit   resp;
        exp_t e;
        @(negedge clk);
        resp          = pend && (pend_cnt == 0);
        mem_rsp_valid = resp;
        mem_rsp_data  = resp ? mkdata(pend_addr) : $urandom;
        mem_req_ready = rdy;
        target_valide = tv | fl;
        flush         = fl;
        target        = tgt;
        instr_ready   = dec_rdy;
        #1;
        check_eq("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        check_eq("mem_req_valid", 32'(mem_req_valid), 32'(!pend && exp_q.size() < DEPTH));
        check_eq("mem_req_addr", mem_req_addr, exp_pc);
        if (instr_valid && dec_rdy && !fl && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("instr", instr, e.data);
            check_eq("instr_pc", instr_pc, e.pc);
        end
        if (resp) begin
            pend = 1'b0;
            if (!discard && !fl) exp_q.push_back('{mkdata(pend_addr), pend_addr});
        end else if (pend) begin
            pend_cnt--;
        end
        if (mem_req_valid && rdy) begin
            pend      = 1'b1;
            pend_cnt  = lat - 1;
            pend_addr = exp_pc;
            discard   = 1'b0;
            exp_pc    = (tv | fl) ? align(tgt) : exp_pc + 32'd4;
        end else if (tv | fl) begin
            exp_pc = align(tgt);
        end
        if (fl) begin
            discard = 1'b1;
            exp_q.delete();
        end
    endtask

    task automatic idle_inputs();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        target_valide = 1'b0;
        flush         = 1'b0;
        instr_ready   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        check_eq({tag, "_req_addr"}, mem_req_addr, RST_PC);
        check_eq({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check_eq({tag, "_instr"}, instr, 32'd0);
        check_eq({tag, "_instr_pc"}, instr_pc, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        pend   = 1'b0;
        exp_q.delete();
        exp_pc = RST_PC;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        #1 check_reset_outputs("por_hold");
        release_reset();

        // Straight-line fetch with a 1-cycle memory and an always-ready decoder.
        lat = 1; dec_rdy = 1'b1;
        cycle(1, 0, 0, '0);
        check_eq("first_accept_addr", pend_addr, 32'h0);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, '0);

        // Decoder stalled: buffer fills to depth and requests stop.
        dec_rdy = 1'b0;
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, '0);
        check_eq("full_no_req", 32'(mem_req_valid), 32'd0);
        check_eq("full_instr_valid", 32'(instr_valid), 32'd1);

        // Redirect without flush keeps buffered words, next request at aligned target.
        cycle(1, 1, 0, 32'h0000_0203);
        @(posedge clk); #1;
        check_eq("redirect_addr", mem_req_addr, 32'h0000_0200);
        check_eq("redirect_kept", 32'(instr_valid), 32'd1);
        dec_rdy = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, '0);

        // Flush while a slow request to 0x8 is outstanding.
        dec_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs("rst2");
        release_reset();
        lat = 3; dec_rdy = 1'b1;
        for (int i = 0; i < 40 && !(pend && pend_addr == 32'h8); i++) cycle(1, 0, 0, '0);
        check_eq("reach_req_0x8", 32'(pend && pend_addr == 32'h8), 32'd1);
        cycle(1, 0, 1, 32'h0000_0100);
        @(posedge clk); #1;
        check_eq("flush_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("flush_addr", mem_req_addr, 32'h0000_0100);
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, '0);

        // Wrap from the top of the address space.
        lat = 1;
        for (int i = 0; i < 10 && pend; i++) cycle(0, 0, 0, '0);
        cycle(0, 1, 0, 32'hFFFF_FFFC);
        cycle(1, 0, 0, '0);
        check_eq("wrap_accept", pend_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check_eq("wrap_next_addr", mem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, '0);

        // Reset in WAIT_RSP: outputs drop immediately, fetch restarts at reset PC.
        lat = 3;
        for (int i = 0; i < 20 && !pend; i++) cycle(1, 0, 0, '0);
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        release_reset();
        lat = 1;
        cycle(1, 0, 0, '0);
        check_eq("restart_addr", pend_addr, RST_PC);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, '0);

        // Randomised traffic: variable latency, back-pressure, redirects and flushes.
        for (int i = 0; i < 400; i++) begin
            bit          rdy, tv, fl;
            logic [31:0] tgt;
            if (!pend) lat = int'($urandom_range(1, 3));
            dec_rdy = ($urandom_range(0, 2) != 0);
            rdy     = ($urandom_range(0, 3) != 0);
            fl      = ($urandom_range(0, 24) == 0);
            tv      = ($urandom_range(0, 19) == 0);
            tgt     = $urandom;
            cycle(rdy, tv, fl, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of instruction buffer entries (power of two, minimum 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port target, input, xlen, the redirect address from PC control.
REQ-006 SHALL have port target_valide, input, 1, a qualifier that applies target as the next fetch PC.
REQ-007 SHALL have port flush, input, 1, which kills buffered and in-flight fetches; it is always accompanied by target_valide.
REQ-008 SHALL have port mem_req_valid, output, 1, an instruction memory request.
REQ-009 SHALL have port mem_req_addr, output, xlen, the request address (word aligned).
REQ-010 SHALL have port mem_req_ready, input, 1; memory accepts the request when valid && ready.
REQ-011 SHALL have port mem_rsp_valid, input, 1, a response strobe for the oldest outstanding request.
REQ-012 SHALL have port mem_rsp_data, input, 32, the instruction word.
REQ-013 SHALL have port instr_valid, output, 1, a decode-side valid.
REQ-014 SHALL have port instr, output, 32, the buffered instruction.
REQ-015 SHALL have port instr_pc, output, xlen, the PC of instr.
REQ-016 SHALL have port instr_ready, input, 1; decode consumes on instr_valid && instr_ready.

Function
REQ-017 SHALL keep the fetch PC register; target[1:0] SHALL be ignored (PC forced word aligned).
REQ-018 SHALL allow at most one outstanding memory request.
REQ-019 SHALL assert mem_req_valid only in FETCH when (fifo_count + outstanding) < FIFO_DEPTH; mem_req_addr = PC.
REQ-020 On request acceptance, PC SHALL advance by 4 (mod 2^xlen, wrap at all-ones with no fault) and state SHALL become WAIT_RSP.
REQ-021 mem_req_valid/addr SHALL be held stable until accepted, unless target_valide arrives, which re-points addr the next cycle.
REQ-022 States SHALL be FETCH, WAIT_RSP, DRAIN: FETCH->WAIT_RSP on accept; WAIT_RSP->FETCH on mem_rsp_valid; WAIT_RSP->DRAIN on flush without simultaneous mem_rsp_valid; DRAIN->FETCH on mem_rsp_valid (data discarded).
REQ-023 In WAIT_RSP, mem_rsp_valid SHALL push {data, request PC} into the FIFO; instr_valid SHALL rise the following cycle (1-cycle response-to-decode latency).
REQ-024 target_valide without flush SHALL load PC only; FIFO and in-flight fetch are preserved.
REQ-025 flush SHALL, in the same edge, empty the FIFO, load PC from target, and discard any in-flight or same-cycle response; instr_valid SHALL be 0 the next cycle.
REQ-026 A flush in DRAIN SHALL reload PC and remain in DRAIN.
REQ-027 Simultaneous push and pop SHALL keep the count unchanged; push when full cannot occur (guaranteed by REQ-019); pop when empty SHALL be ignored.
REQ-028 A flush SHALL take priority over instr_ready pop and response push in the same cycle.

Reset
REQ-029 While rst=1: PC=RESET_PC, state=FETCH, FIFO empty, outstanding=0, mem_req_valid=0, instr_valid=0, mem_req_addr=RESET_PC, instr=0, instr_pc=0.
REQ-030 First request SHALL issue in the first cycle after rst deasserts; a response arriving during or after a mid-operation reset for a pre-reset request SHALL be ignored only if it arrives while rst=1 (memory is reset together).

Structure
REQ-031 xlen and the state enum type SHALL live in cpu_parameters; RESET_PC stays a module parameter.
REQ-032 The instruction buffer SHALL be a sub-module ifetch_fifo (parameterised width/depth, push/pop/clear, count output).

Verification
REQ-033 Reset release, mem_req_ready=1, 1-cycle memory -> requests at 0x0,0x4,0x8; instr_pc 0x0 valid 2 cycles after first accept.
REQ-034 instr_ready=0 with depth 2 -> exactly 2 words buffered, mem_req_valid then held 0 until a pop.
REQ-035 Flush with target=0x100 while a request to 0x8 is outstanding -> late response dropped, next request addr 0x100, instr_valid 0 until 0x100 returns.
REQ-036 target_valide=1, flush=0, target=0x203 -> buffered words kept, next request addr 0x200.
REQ-037 PC=0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
REQ-038 rst asserted mid-WAIT_RSP -> all outputs at reset values within the same cycle, fetch restarts at RESET_PC.
